// File: rtl/fifo_rd_ctrl_pkg.sv
// Shared widths, pointer type, output-stage states and Gray helpers for the
// read side of the asynchronous FIFO.
package definitions;

  localparam int ADDRSIZE = 4;
  localparam int DATASIZE = 8;

  typedef logic [ADDRSIZE:0] ptr_t;

  typedef enum logic {
    OS_IDLE,
    OS_FULL
  } ostage_t;

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[ADDRSIZE] = g[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_sync_2ff.sv
// Two-flop synchronizer used to bring the Gray write pointer into rclk.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-domain controller of the async FIFO with a first-word-fall-through output stage.
// Optional registered almost-empty flag enabled by defining FIFO_RD_ALMOST_EMPTY_EN.
module fifo_rd_ctrl #(
  parameter int ADDRSIZE = definitions::ADDRSIZE,
  parameter int DATASIZE = definitions::DATASIZE
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  , parameter int AE_THRESH = 2
`endif
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic [ADDRSIZE:0]   wptr_gray_i,
  input  logic [DATASIZE-1:0] rdata_mem_i,
  output logic [ADDRSIZE-1:0] raddr_o,
  output logic [ADDRSIZE:0]   rptr_gray_o,
  input  logic                rready_i,
  output logic                rvalid_o,
  output logic [DATASIZE-1:0] rdata_o,
  output logic                rempty_o,
  output logic [ADDRSIZE:0]   rlevel_o
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  , output logic              ralmost_empty_o
`endif
);

  definitions::ostage_t ostate;

  logic [ADDRSIZE:0] rq2_wptr;
  logic [ADDRSIZE:0] wq_bin;
  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbin_next;
  logic              mem_empty;
  logic              pop;

  sync_2ff #(
    .WIDTH(ADDRSIZE + 1)
  ) u_wptr_sync (
    .clk  (rclk),
    .rst_n(rrst_n),
    .d    (wptr_gray_i),
    .q    (rq2_wptr)
  );

  // Width-generic Gray-to-binary of the synchronized write pointer.
  always_comb begin
    wq_bin           = '0;
    wq_bin[ADDRSIZE] = rq2_wptr[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      wq_bin[i] = wq_bin[i+1] ^ rq2_wptr[i];
    end
  end

  assign mem_empty = (rptr_gray_o == rq2_wptr);
  assign pop       = !mem_empty && (!rvalid_o || rready_i);
  assign rbin_next = rbin + 1'b1;
  assign raddr_o   = rbin[ADDRSIZE-1:0];
  assign rvalid_o  = (ostate == definitions::OS_FULL);
  assign rempty_o  = mem_empty && !rvalid_o;
  assign rlevel_o  = wq_bin - rbin;

  // Pointer advance and the output-stage state share one register block so a
  // pop always loads the word and moves the pointer on the same edge.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin        <= '0;
      rptr_gray_o <= '0;
      rdata_o     <= '0;
      ostate      <= definitions::OS_IDLE;
    end else begin
      if (pop) begin
        rbin        <= rbin_next;
        rptr_gray_o <= rbin_next ^ (rbin_next >> 1);
        rdata_o     <= rdata_mem_i;
      end
      case (ostate)
        definitions::OS_IDLE: if (pop) ostate <= definitions::OS_FULL;
        definitions::OS_FULL: if (rready_i && !pop) ostate <= definitions::OS_IDLE;
        default:              ostate <= definitions::OS_IDLE;
      endcase
    end
  end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
  localparam logic [ADDRSIZE:0] AE_LVL = AE_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] level_next;

  // Looks ahead through this cycle's pop; newly arriving writes show up one
  // cycle later, which only ever holds the flag asserted a little longer.
  assign level_next = wq_bin - (pop ? rbin_next : rbin);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) ralmost_empty_o <= 1'b1;
    else         ralmost_empty_o <= (level_next <= AE_LVL);
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed self-checking bench for fifo_rd_ctrl (default widths, 16-entry RAM model).
module tb_fifo_rd_ctrl;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic [AW:0]   wptr_gray;
  logic [DW-1:0] rdata_mem;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr_gray;
  logic          rready;
  logic          rvalid;
  logic [DW-1:0] rdata;
  logic          rempty;
  logic [AW:0]   rlevel;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic          ralmost_empty;
`endif

  logic [DW-1:0] mem [16];

  int assertions = 0;
  int failures   = 0;
  int wbin;
  int wcount;
  int rx;
  int got;

  always #5 rclk = ~rclk;

  assign rdata_mem = mem[raddr];

  fifo_rd_ctrl dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .wptr_gray_i(wptr_gray),
    .rdata_mem_i(rdata_mem),
    .raddr_o    (raddr),
    .rptr_gray_o(rptr_gray),
    .rready_i   (rready),
    .rvalid_o   (rvalid),
    .rdata_o    (rdata),
    .rempty_o   (rempty),
    .rlevel_o   (rlevel)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    , .ralmost_empty_o(ralmost_empty)
`endif
  );

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return v ^ (v >> 1);
  endfunction

  function automatic logic [DW-1:0] wordVal(input int n);
    logic [31:0] v;
    v = n * 37 + 11;
    return v[DW-1:0];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [AW:0] wg, input logic rdy);
    wptr_gray = wg;
    rready    = rdy;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertions++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic doReset();
    @(posedge rclk);
    #3;
    rrst_n = 1'b0;
    applyStimulus('0, 1'b0);
    @(negedge rclk);
    rrst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i * 5);
    rrst_n = 1'b0;
    applyStimulus('0, 1'b0);
    #2;
    checkOutput("rst_rempty", rempty, 1);
    checkOutput("rst_rvalid", rvalid, 0);
    checkOutput("rst_rlevel", rlevel, 0);
    checkOutput("rst_raddr", raddr, 0);
    checkOutput("rst_rptr", rptr_gray, 0);
    #10;
    rrst_n = 1'b1;

    $display("[TB] single word, latency and hold");
    tick(1);
    applyStimulus(5'h01, 1'b0);
    tick(1);
    checkOutput("lat_n_empty", rempty, 1);
    tick(1);
    checkOutput("lat_n1_valid", rvalid, 0);
    checkOutput("lat_n1_empty", rempty, 0);
    checkOutput("lat_n1_level", rlevel, 1);
    tick(1);
    checkOutput("lat_n2_valid", rvalid, 1);
    checkOutput("lat_n2_data", rdata, mem[0]);
    checkOutput("lat_n2_level", rlevel, 0);
    checkOutput("lat_n2_empty", rempty, 0);
    checkOutput("lat_n2_rptr", rptr_gray, 5'h01);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      checkOutput("hold_word", {rvalid, rdata}, {1'b1, mem[0]});
    end

    $display("[TB] asynchronous reset mid-transfer");
    #3;
    rrst_n = 1'b0;
    #1;
    checkOutput("arst_rvalid", rvalid, 0);
    checkOutput("arst_rempty", rempty, 1);
    checkOutput("arst_rlevel", rlevel, 0);
    checkOutput("arst_raddr", raddr, 0);
    checkOutput("arst_rptr", rptr_gray, 0);
    applyStimulus('0, 1'b0);
    @(negedge rclk);
    rrst_n = 1'b1;

    $display("[TB] eight-word streaming burst");
    tick(1);
    applyStimulus(5'h0C, 1'b1);
    tick(2);
    for (int k = 0; k < 8; k++) begin
      tick(1);
      checkOutput("burst_word", {rvalid, rdata}, {1'b1, mem[k]});
      if (k == 0) checkOutput("burst_level0", rlevel, 7);
    end
    tick(1);
    checkOutput("burst_end_valid", rvalid, 0);
    checkOutput("burst_end_empty", rempty, 1);
    checkOutput("burst_end_rptr", rptr_gray, 5'h0C);
    tick(3);
    checkOutput("idle_ready_rptr", rptr_gray, 5'h0C);
    checkOutput("idle_ready_valid", rvalid, 0);

    $display("[TB] full FIFO and drain");
    doReset();
    applyStimulus(5'h18, 1'b0);
    tick(2);
    checkOutput("full_level16", rlevel, 16);
    checkOutput("full_pre_valid", rvalid, 0);
    tick(1);
    checkOutput("full_level15", rlevel, 15);
    checkOutput("full_rptr", rptr_gray, 5'h01);
    checkOutput("full_word0", {rvalid, rdata}, {1'b1, mem[0]});
    rready = 1'b1;
    for (int k = 1; k < 16; k++) begin
      tick(1);
      checkOutput("drain_word", {rvalid, rdata}, {1'b1, mem[k]});
    end
    tick(1);
    checkOutput("drain_end_valid", rvalid, 0);
    checkOutput("drain_end_empty", rempty, 1);
    checkOutput("drain_end_rptr", rptr_gray, 5'h18);
    checkOutput("drain_end_level", rlevel, 0);

    $display("[TB] pointer wrap over 40 words");
    wbin   = 16;
    wcount = 0;
    rx     = 0;
    for (int b = 0; b < 5; b++) begin
      for (int j = 0; j < 8; j++) begin
        mem[wbin % 16] = wordVal(wcount);
        wcount++;
        wbin = (wbin + 1) % 32;
      end
      applyStimulus(gray(wbin), 1'b1);
      got = 0;
      for (int c = 0; c < 20 && got < 8; c++) begin
        tick(1);
        checkOutput("wrap_level_max", {31'd0, rlevel <= 5'd16}, 1);
        if (rvalid) begin
          checkOutput("wrap_word", rdata, wordVal(rx));
          rx++;
          got++;
        end
      end
      checkOutput("wrap_burst_count", got, 8);
      tick(1);
      checkOutput("wrap_burst_empty", rempty, 1);
    end
    checkOutput("wrap_final_rptr", rptr_gray, 5'h14);

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    $display("[TB] almost-empty flag");
    doReset();
    checkOutput("ae_reset", ralmost_empty, 1);
    applyStimulus(5'h07, 1'b0);
    tick(3);
    checkOutput("ae_level4", rlevel, 4);
    checkOutput("ae_low", ralmost_empty, 0);
    rready = 1'b1;
    tick(1);
    checkOutput("ae_level3", ralmost_empty, 0);
    tick(1);
    checkOutput("ae_level2_lvl", rlevel, 2);
    checkOutput("ae_level2", ralmost_empty, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
